mdu_ctrl: RTL and testbench

- Multi-cycle multiply/divide controller placed beside the execute-stage ALU.
- Accepts mult/multu/div/divu/mthi/mtlo commands and owns the HI/LO registers.
- Models fixed-latency execution with a Busy handshake, so the hazard unit can stall dependent MDU instructions in decode.
- Also provides the HI/LO read path for mfhi/mflo.

---
 rtl/mdu_ctrl.sv | 128 ++++++++++++
 tb/tb_mdu_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: fixed-latency multiply/divide controller that owns HI/LO and drives the MDU stall.
// Optional madd/maddu (MDUOp 7/8) are compiled in only when MDU_MADD_EN is defined.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        DUseMDU,
  output logic        Busy,
  output logic        MDUStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
`endif

  typedef enum logic {StIdle, StBusy} state_e;

  state_e          r_state;
  logic            r_busy;
  logic [CntW-1:0] r_cnt;
  logic [31:0]     r_hi, r_lo, r_phi, r_plo;
  logic            r_pvalid;

  logic        w_op_mult, w_op_div, w_op_multi, w_signed, w_div_zero;
  logic [63:0] w_opa, w_opb, w_prod, w_res;
  logic [31:0] w_abs_a, w_abs_b, w_div_b, w_uq, w_ur, w_q, w_r;

  always_comb begin
    w_op_mult = (MDUOp == OpMult) || (MDUOp == OpMultu);
`ifdef MDU_MADD_EN
    w_op_mult = w_op_mult || (MDUOp == OpMadd) || (MDUOp == OpMaddu);
`endif
    w_op_div = (MDUOp == OpDiv) || (MDUOp == OpDivu);
  end

  assign w_op_multi = w_op_mult | w_op_div;
  // Signed variants (mult, div, madd) all have odd opcodes.
  assign w_signed   = MDUOp[0];
  assign w_div_zero = (SrcB == 32'd0);

  assign w_opa  = w_signed ? {{32{SrcA[31]}}, SrcA} : {32'd0, SrcA};
  assign w_opb  = w_signed ? {{32{SrcB[31]}}, SrcB} : {32'd0, SrcB};
  assign w_prod = w_opa * w_opb;

  // Signed divide on magnitudes; keeps 0x80000000 / -1 well defined.
  assign w_abs_a = (w_signed && SrcA[31]) ? -SrcA : SrcA;
  assign w_abs_b = (w_signed && SrcB[31]) ? -SrcB : SrcB;
  assign w_div_b = w_div_zero ? 32'd1 : w_abs_b;
  assign w_uq    = w_abs_a / w_div_b;
  assign w_ur    = w_abs_a % w_div_b;
  assign w_q     = (w_signed && (SrcA[31] ^ SrcB[31])) ? -w_uq : w_uq;
  assign w_r     = (w_signed && SrcA[31]) ? -w_ur : w_ur;

  always_comb begin
    w_res = w_op_div ? {w_r, w_q} : w_prod;
`ifdef MDU_MADD_EN
    if ((MDUOp == OpMadd) || (MDUOp == OpMaddu)) w_res = {r_hi, r_lo} + w_prod;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_phi    <= 32'd0;
      r_plo    <= 32'd0;
      r_pvalid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (Start) begin
            if (w_op_multi) begin
              {r_phi, r_plo} <= w_res;
              r_pvalid       <= !(w_op_div && w_div_zero);
              r_cnt          <= w_op_div ? CntW'(DIV_CYCLES - 1) : CntW'(MULT_CYCLES - 1);
              r_busy         <= 1'b1;
              r_state        <= StBusy;
            end else if (MDUOp == OpMthi) begin
              r_hi <= SrcA;
            end else if (MDUOp == OpMtlo) begin
              r_lo <= SrcA;
            end
          end
        end
        StBusy: begin
          if (r_cnt == '0) begin
            if (r_pvalid) begin
              r_hi <= r_phi;
              r_lo <= r_plo;
            end
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end else begin
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign Busy     = r_busy;
  assign HI       = r_hi;
  assign LO       = r_lo;
  assign MDUStall = DUseMDU & (r_busy | (Start & w_op_multi));

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized ops against an arithmetic model.
module tb_mdu_ctrl;

  localparam int unsigned MultN = 5;
  localparam int unsigned DivN  = 10;

  logic        clk = 1'b0;
  logic        reset, Start, DUseMDU, Busy, MDUStall;
  logic [3:0]  MDUOp;
  logic [31:0] SrcA, SrcB, HI, LO;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(MultN), .DIV_CYCLES(DivN)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .SrcA(SrcA), .SrcB(SrcB),
    .DUseMDU(DUseMDU), .Busy(Busy), .MDUStall(MDUStall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [3:0] op);
    case (op)
      4'd1, 4'd2: return MultN;
      4'd3, 4'd4: return DivN;
`ifdef MDU_MADD_EN
      4'd7, 4'd8: return MultN;
`endif
      default:    return 0;
    endcase
  endfunction

  // Architectural effect of one command on HI/LO.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: {exp_hi, exp_lo} = sa * sb;
      4'd2: {exp_hi, exp_lo} = ua * ub;
      4'd3: if (b != 0) begin
        exp_lo = 32'(sa / sb);
        exp_hi = 32'(sa % sb);
      end
      4'd4: if (b != 0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      4'd5: exp_hi = a;
      4'd6: exp_lo = a;
`ifdef MDU_MADD_EN
      4'd7: {exp_hi, exp_lo} = {exp_hi, exp_lo} + sa * sb;
      4'd8: {exp_hi, exp_lo} = {exp_hi, exp_lo} + ua * ub;
`endif
      default: ;
    endcase
  endtask

  // Issue one command, measure Busy length, check stall and HI/LO hold/commit.
  // poke=1 fires a stray Start during Busy, which must be ignored.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic duse, input logic poke);
    logic [31:0] old_hi, old_lo;
    int lat, n;
    lat    = lat_of(op);
    old_hi = exp_hi;
    old_lo = exp_lo;
    @(negedge clk);
    Start = 1'b1; MDUOp = op; SrcA = a; SrcB = b; DUseMDU = duse;
    #1 check_eq("stall_start", {63'd0, MDUStall}, {63'd0, (duse && (lat > 0))});
    model(op, a, b);
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    n = 0;
    while (Busy && n < 100) begin
      check_eq("stall_busy", {63'd0, MDUStall}, {63'd0, duse});
      check_eq("hold", {HI, LO}, {old_hi, old_lo});
      if (poke && n == 1) begin
        Start = 1'b1; MDUOp = 4'($urandom_range(1, 6)); SrcA = $urandom; SrcB = $urandom;
      end else begin
        Start = 1'b0; MDUOp = 4'd0;
      end
      n++;
      @(negedge clk);
    end
    Start = 1'b0; MDUOp = 4'd0;
    check_eq("busy_len", 64'(n), 64'(lat));
    check_eq("hilo", {HI, LO}, {exp_hi, exp_lo});
    check_eq("stall_after", {63'd0, MDUStall}, 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] corners [5];
    corners = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return $urandom;
  endfunction

  initial begin
    logic [3:0] op;
    int r;
    reset = 1'b1; Start = 1'b0; MDUOp = 4'd0; SrcA = 32'd0; SrcB = 32'd0; DUseMDU = 1'b1;
    #1;
    check_eq("rst_busy", {63'd0, Busy}, 64'd0);
    check_eq("rst_hilo", {HI, LO}, 64'd0);
    check_eq("rst_stall", {63'd0, MDUStall}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    do_op(4'd1, 32'hFFFFFFFE, 32'd3, 1'b1, 1'b0);
    check_eq("mult_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFA);
    do_op(4'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
    check_eq("multu_const", {HI, LO}, 64'h00000001_FFFFFFFE);
    do_op(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
    check_eq("div_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4'd3, 32'h12345678, 32'd0, 1'b1, 1'b0);
    check_eq("div0_const", {HI, LO}, 64'hFFFFFFFF_FFFFFFFD);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    check_eq("div_ovf_const", {HI, LO}, 64'h00000000_80000000);

    // Back-to-back mthi / mtlo.
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'd5; SrcA = 32'h12345678; DUseMDU = 1'b1;
    @(negedge clk);
    check_eq("mthi_hi", {32'd0, HI}, {32'd0, 32'h12345678});
    check_eq("mthi_busy", {63'd0, Busy}, 64'd0);
    MDUOp = 4'd6; SrcA = 32'h9ABCDEF0;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    check_eq("mtlo_lo", {32'd0, LO}, {32'd0, 32'h9ABCDEF0});
    check_eq("mtlo_busy", {63'd0, Busy}, 64'd0);
    exp_hi = 32'h12345678;
    exp_lo = 32'h9ABCDEF0;

    do_op(4'd1, 32'd1234, 32'hFFFF0000, 1'b1, 1'b1);

    do_op(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    do_op(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0);
    do_op(4'd8, 32'd1, 32'd1, 1'b1, 1'b0);
`ifdef MDU_MADD_EN
    check_eq("maddu_const", {HI, LO}, 64'h00000001_00000000);
`else
    check_eq("maddu_off_const", {HI, LO}, 64'h00000000_FFFFFFFF);
`endif

    for (int i = 9; i < 16; i++) do_op(4'(i), $urandom, $urandom, 1'b1, 1'b0);
    do_op(4'd0, $urandom, $urandom, 1'b1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      op = (r == 9) ? 4'($urandom_range(9, 15)) : 4'(r);
      do_op(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
            (lat_of(op) >= 3) && ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset in the middle of a divu.
    do_op(4'd5, 32'hCAFE0001, 32'd0, 1'b0, 1'b0);
    do_op(4'd6, 32'hBEEF0002, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    Start = 1'b1; MDUOp = 4'd4; SrcA = 32'd100; SrcB = 32'd7; DUseMDU = 1'b0;
    @(negedge clk);
    Start = 1'b0; MDUOp = 4'd0;
    repeat (3) @(posedge clk);
    #1 check_eq("pre_rst_busy", {63'd0, Busy}, 64'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("arst_busy", {63'd0, Busy}, 64'd0);
    check_eq("arst_hilo", {HI, LO}, 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check_eq("post_rst_busy", {63'd0, Busy}, 64'd0);
    check_eq("post_rst_hilo", {HI, LO}, {exp_hi, exp_lo});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
